// File: rtl/mips_pkg.sv
// Shared widths and encodings for the 16-bit pipelined MIPS datapath.
// Memory-direction constants match the mem_rw encoding driven by decode.
package mips_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int TAG_W  = 3;

   localparam logic MEM_READ  = 1'b0;
   localparam logic MEM_WRITE = 1'b1;

   // Control half of the MEM/WB pipeline register.
   typedef struct packed {
      logic [TAG_W-1:0] rd;
      logic             wb_en;
      logic             valid;
      logic             load;
   } mem_wb_ctl_t;

endpackage

// File: rtl/dm_ram.sv
// DEPTH x DATA_W data memory: synchronous write, asynchronous read, no reset.
// Single port, so a read sees the contents from before the write at the same edge.
module dm_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/data_memory_block.sv
// MEM stage: performs the load/store for the EX/MEM slot and registers the result (1 cycle).
// stall freezes the MEM/WB register and blocks the write; flush or invalid EX inserts a bubble.
module data_memory_block #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] b_data_ex,
   input  logic              mem_en_ex,
   input  logic              mem_rw_ex,
   input  logic [2:0]        rd_ex,
   input  logic              wb_en_ex,
   input  logic              valid_ex,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] ans_dm,
   output logic [2:0]        rd_dm,
   output logic              wb_en_dm,
   output logic              valid_dm,
   output logic [DATA_W-1:0] fwd_data,
   output logic              load_dm
);

   import mips_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] rd_data;
   logic              acc;
   logic              is_load;
   logic              is_store;
   logic              mem_we;

   logic [DATA_W-1:0] ans_d, ans_q;
   mem_wb_ctl_t       ctl_d, ctl_q;

   // Upper address bits are dropped, so addresses wrap modulo DEPTH.
   assign addr     = ans_ex[ADDR_W-1:0];
   assign acc      = valid_ex & ~flush & ~stall;
   assign is_load  = mem_en_ex & (mem_rw_ex == MEM_READ);
   assign is_store = mem_en_ex & (mem_rw_ex == MEM_WRITE);
   // Gating with reset keeps a store that races an asserting reset from landing.
   assign mem_we   = acc & is_store & reset;

   dm_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_dm_ram (
      .clk   (clk),
      .we    (mem_we),
      .addr  (addr),
      .wdata (b_data_ex),
      .rdata (rd_data)
   );

   always_comb begin
      ans_d = ans_q;
      ctl_d = ctl_q;
      if (!stall) begin
         ans_d       = is_load ? rd_data : ans_ex;
         ctl_d.rd    = rd_ex;
         ctl_d.valid = acc;
         ctl_d.wb_en = acc & wb_en_ex & ~is_store;
         ctl_d.load  = acc & is_load;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ans_q <= '0;
         ctl_q <= '0;
      end else begin
         ans_q <= ans_d;
         ctl_q <= ctl_d;
      end
   end

   assign ans_dm   = ans_q;
   assign fwd_data = ans_q;
   assign rd_dm    = ctl_q.rd;
   assign wb_en_dm = ctl_q.wb_en;
   assign valid_dm = ctl_q.valid;
   assign load_dm  = ctl_q.load;

endmodule

// File: tb/tb_data_memory_block.sv
// Directed vector bench for data_memory_block: table of per-cycle stimulus and
// expected MEM/WB outputs, plus hand sequences for reset behaviour.
module tb_data_memory_block;

   logic        clk;
   logic        reset;
   logic [15:0] ans_ex;
   logic [15:0] b_data_ex;
   logic        mem_en_ex;
   logic        mem_rw_ex;
   logic [2:0]  rd_ex;
   logic        wb_en_ex;
   logic        valid_ex;
   logic        stall;
   logic        flush;
   logic [15:0] ans_dm;
   logic [2:0]  rd_dm;
   logic        wb_en_dm;
   logic        valid_dm;
   logic [15:0] fwd_data;
   logic        load_dm;

   int tests_run;
   int tests_failed;

   data_memory_block #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
      .clk       (clk),
      .reset     (reset),
      .ans_ex    (ans_ex),
      .b_data_ex (b_data_ex),
      .mem_en_ex (mem_en_ex),
      .mem_rw_ex (mem_rw_ex),
      .rd_ex     (rd_ex),
      .wb_en_ex  (wb_en_ex),
      .valid_ex  (valid_ex),
      .stall     (stall),
      .flush     (flush),
      .ans_dm    (ans_dm),
      .rd_dm     (rd_dm),
      .wb_en_dm  (wb_en_dm),
      .valid_dm  (valid_dm),
      .fwd_data  (fwd_data),
      .load_dm   (load_dm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ans;
      logic [15:0] b;
      logic        mem_en;
      logic        rw;
      logic [2:0]  rd;
      logic        wb;
      logic        valid;
      logic        stl;
      logic        fls;
      logic [15:0] e_ans;
      logic [2:0]  e_rd;
      logic        e_wb;
      logic        e_v;
      logic        e_ld;
      logic        chk_ans;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   function automatic vec_t mk(logic [15:0] ans, logic [15:0] b, logic mem_en, logic rw,
                               logic [2:0] rd, logic wb, logic valid, logic stl, logic fls,
                               logic [15:0] e_ans, logic [2:0] e_rd, logic e_wb, logic e_v,
                               logic e_ld, logic chk_ans);
      vec_t v;
      v.ans = ans; v.b = b; v.mem_en = mem_en; v.rw = rw; v.rd = rd; v.wb = wb;
      v.valid = valid; v.stl = stl; v.fls = fls;
      v.e_ans = e_ans; v.e_rd = e_rd; v.e_wb = e_wb; v.e_v = e_v; v.e_ld = e_ld;
      v.chk_ans = chk_ans;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [15:0] ans, input logic [15:0] b, input logic mem_en,
                        input logic rw, input logic [2:0] rd, input logic wb, input logic valid,
                        input logic stl, input logic fls);
      ans_ex = ans; b_data_ex = b; mem_en_ex = mem_en; mem_rw_ex = rw; rd_ex = rd;
      wb_en_ex = wb; valid_ex = valid; stall = stl; flush = fls;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      //          ans       b        en rw rd wb v  st fl   e_ans     rd wb v  ld chk
      vecs[0]  = mk(16'h0042, 16'h0000, 0, 0, 1, 1, 1, 0, 0, 16'h0042, 1, 1, 1, 0, 1);
      vecs[1]  = mk(16'h0005, 16'h1234, 1, 1, 2, 0, 1, 0, 0, 16'h0005, 2, 0, 1, 0, 1);
      vecs[2]  = mk(16'h0005, 16'h0000, 1, 0, 3, 1, 1, 0, 0, 16'h1234, 3, 1, 1, 1, 1);
      vecs[3]  = mk(16'h0103, 16'hA5A5, 1, 1, 4, 0, 1, 0, 0, 16'h0103, 4, 0, 1, 0, 1);
      vecs[4]  = mk(16'h0003, 16'h0000, 1, 0, 5, 1, 1, 0, 0, 16'hA5A5, 5, 1, 1, 1, 1);
      vecs[5]  = mk(16'h0020, 16'h0001, 1, 1, 0, 0, 1, 0, 0, 16'h0020, 0, 0, 1, 0, 1);
      vecs[6]  = mk(16'h0010, 16'h7777, 1, 1, 6, 1, 1, 1, 0, 16'h0020, 0, 0, 1, 0, 1);
      vecs[7]  = mk(16'h0010, 16'h7777, 1, 1, 6, 1, 1, 1, 0, 16'h0020, 0, 0, 1, 0, 1);
      vecs[8]  = mk(16'h0010, 16'h7777, 1, 1, 6, 1, 1, 1, 0, 16'h0020, 0, 0, 1, 0, 1);
      vecs[9]  = mk(16'h0010, 16'h7777, 1, 1, 6, 1, 1, 0, 0, 16'h0010, 6, 0, 1, 0, 1);
      vecs[10] = mk(16'h0010, 16'h0000, 1, 0, 7, 1, 1, 0, 0, 16'h7777, 7, 1, 1, 1, 1);
      vecs[11] = mk(16'h0020, 16'h5555, 1, 1, 1, 0, 1, 0, 1, 16'h0020, 1, 0, 0, 0, 1);
      vecs[12] = mk(16'h0020, 16'h0000, 1, 0, 2, 1, 1, 0, 0, 16'h0001, 2, 1, 1, 1, 1);
      vecs[13] = mk(16'h0020, 16'h0000, 1, 0, 3, 1, 0, 0, 0, 16'h0000, 3, 0, 0, 0, 0);
      vecs[14] = mk(16'h0005, 16'h0000, 1, 0, 4, 1, 1, 1, 1, 16'h0000, 3, 0, 0, 0, 0);
      vecs[15] = mk(16'h1111, 16'h0000, 0, 0, 5, 0, 1, 0, 0, 16'h1111, 5, 0, 1, 0, 1);
      vecs[16] = mk(16'h0003, 16'h0000, 1, 0, 6, 1, 1, 1, 0, 16'h1111, 5, 0, 1, 0, 1);

      // Reset held: outputs must be zero regardless of EX activity.
      reset = 1'b0;
      drive(16'hBEEF, 16'h0000, 0, 0, 0, 1, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst ans_dm", {16'h0, ans_dm}, 32'h0);
      chk("rst fwd_data", {16'h0, fwd_data}, 32'h0);
      chk("rst ctl", {28'h0, rd_dm, wb_en_dm, valid_dm, load_dm}, 32'h0);

      reset = 1'b1;
      #1;
      chk("rst release no edge", {16'h0, ans_dm}, 32'h0);
      @(negedge clk);
      chk("first alu ans_dm", {16'h0, ans_dm}, 32'h0000BEEF);
      chk("first alu ctl", {28'h0, rd_dm, wb_en_dm, valid_dm, load_dm}, {28'h0, 3'd0, 1'b1, 1'b1, 1'b0});

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].ans, vecs[i].b, vecs[i].mem_en, vecs[i].rw, vecs[i].rd,
               vecs[i].wb, vecs[i].valid, vecs[i].stl, vecs[i].fls);
         @(negedge clk);
         chk($sformatf("v%0d ctl", i), {28'h0, rd_dm, wb_en_dm, valid_dm, load_dm},
             {28'h0, vecs[i].e_rd, vecs[i].e_wb, vecs[i].e_v, vecs[i].e_ld});
         if (vecs[i].chk_ans) begin
            chk($sformatf("v%0d ans_dm", i), {16'h0, ans_dm}, {16'h0, vecs[i].e_ans});
            chk($sformatf("v%0d fwd_data", i), {16'h0, fwd_data}, {16'h0, vecs[i].e_ans});
         end
      end

      // Reset falling before the edge must block a pending store.
      drive(16'h0030, 16'h0BAD, 1, 1, 0, 0, 1, 0, 0);
      @(negedge clk);
      drive(16'h0030, 16'h9999, 1, 1, 0, 0, 1, 0, 0);
      #2 reset = 1'b0;
      #1;
      chk("midstore rst ans_dm", {16'h0, ans_dm}, 32'h0);
      chk("midstore rst valid_dm", {31'h0, valid_dm}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      drive(16'h0030, 16'h0000, 1, 0, 2, 1, 1, 0, 0);
      @(negedge clk);
      chk("midstore load ans_dm", {16'h0, ans_dm}, 32'h00000BAD);
      chk("midstore load ctl", {28'h0, rd_dm, wb_en_dm, valid_dm, load_dm},
          {28'h0, 3'd2, 1'b1, 1'b1, 1'b1});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
